// File: rtl/pyhdl_if_call_arbiter_if.sv
// Signal bundle between the call arbiter, its requesting BFMs and the upstream pyhdl_if call endpoint.
// A transfer happens on a rising edge where valid and ready are both high; a raised valid and its payload stay stable until then.
interface pyhdl_if_call_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int ID_W   = 8,
    parameter int DATA_W = 32
);
    localparam int TAG_W = $clog2(N_REQ);

    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*ID_W-1:0]   req_method;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [N_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]       rsp_data;
    logic                    rsp_err;
    logic                    call_valid;
    logic                    call_ready;
    logic [ID_W-1:0]         call_method;
    logic [DATA_W-1:0]       call_data;
    logic [TAG_W-1:0]        call_tag;
    logic                    ret_valid;
    logic                    ret_ready;
    logic [DATA_W-1:0]       ret_data;
    logic [TAG_W-1:0]        ret_tag;

    modport master (
        input  req_valid, req_method, req_data, call_ready, ret_valid, ret_data, ret_tag,
        output req_ready, rsp_valid, rsp_data, rsp_err, call_valid, call_method, call_data,
               call_tag, ret_ready
    );

    modport slave (
        output req_valid, req_method, req_data, call_ready, ret_valid, ret_data, ret_tag,
        input  req_ready, rsp_valid, rsp_data, rsp_err, call_valid, call_method, call_data,
               call_tag, ret_ready
    );
endinterface

// File: rtl/pyhdl_if_call_arbiter.sv
// Round-robin arbiter sharing one tagged HDL-to-Python call channel among N_REQ BFMs,
// with one outstanding call, a return timeout and a one-cycle response pulse per grant.
module pyhdl_if_call_arbiter #(
    parameter int N_REQ   = 4,
    parameter int ID_W    = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                    clock,
    input  logic                    reset,
    pyhdl_if_call_arbiter_if.master bus,
    output logic                    busy,
    output logic                    stray_ret,
    output logic [1:0]              o_state
);
    localparam int TAG_W = $clog2(N_REQ);
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [N_REQ-1:0] ONE_HOT0 = N_REQ'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic [TAG_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic [ID_W-1:0]     r_method;
    logic [DATA_W-1:0]   r_data;
    logic [TAG_W-1:0]    r_tag;
    logic [DATA_W-1:0]   r_rsp_data;
    logic                r_rsp_err;
    logic                r_stray;

    logic                w_found;
    logic [TAG_W-1:0]    w_winner;
    logic                w_grant;
    logic                w_ret_match;
    logic                w_timeout;

    // First requester at or above the round-robin pointer, wrapping around.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!w_found && bus.req_valid[(int'(r_rr_ptr) + i) % N_REQ]) begin
                w_found  = 1'b1;
                w_winner = TAG_W'((int'(r_rr_ptr) + i) % N_REQ);
            end
        end
    end

    assign w_ret_match = (r_state == S_WAIT) && bus.ret_valid && (bus.ret_tag == r_tag);
    assign w_timeout   = (TIMEOUT != 0) && (r_cnt == CNT_LAST);

    always_comb begin
        w_next  = r_state;
        w_grant = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_grant = 1'b1;
                    w_next  = S_ISSUE;
                end
            end
            // Timeout beats a same-cycle call handshake; a matching return beats the timeout.
            S_ISSUE: begin
                if (w_timeout)           w_next = S_RESP;
                else if (bus.call_ready) w_next = S_WAIT;
            end
            S_WAIT: begin
                if (w_ret_match || w_timeout) w_next = S_RESP;
            end
            S_RESP:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_method   <= '0;
            r_data     <= '0;
            r_tag      <= '0;
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b0;
            r_stray    <= 1'b0;
        end else begin
            if (w_grant) begin
                r_rr_ptr <= (w_winner == TAG_W'(N_REQ - 1)) ? '0 : w_winner + 1'b1;
                r_method <= bus.req_method[int'(w_winner)*ID_W +: ID_W];
                r_data   <= bus.req_data[int'(w_winner)*DATA_W +: DATA_W];
                r_tag    <= w_winner;
                r_cnt    <= '0;
            end else if (r_state == S_ISSUE || r_state == S_WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_ret_match) begin
                r_rsp_data <= bus.ret_data;
                r_rsp_err  <= 1'b0;
            end else if (w_next == S_RESP) begin
                r_rsp_data <= '0;
                r_rsp_err  <= 1'b1;
            end
            // ret_ready is high in every state, so every non-matching return is consumed and dropped.
            if (bus.ret_valid && !w_ret_match) r_stray <= 1'b1;
        end
    end

    // Combinational outputs are gated by reset so every output reads 0 while it is asserted.
    assign bus.req_ready   = (w_grant && !reset) ? (ONE_HOT0 << w_winner) : '0;
    assign bus.ret_ready   = !reset;
    assign bus.call_valid  = (r_state == S_ISSUE);
    assign bus.call_method = r_method;
    assign bus.call_data   = r_data;
    assign bus.call_tag    = r_tag;
    assign bus.rsp_valid   = (r_state == S_RESP) ? (ONE_HOT0 << r_tag) : '0;
    assign bus.rsp_data    = r_rsp_data;
    assign bus.rsp_err     = r_rsp_err;
    assign busy            = (r_state != S_IDLE);
    assign stray_ret       = r_stray;
    assign o_state         = r_state;
endmodule
